pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush/forward controller for the 5-stage RV32 pipeline.
//  - Drives en/clr of the F, F/D, D/E, E/M and M/W pipeline registers.
//  - Generates E-stage forwarding selects.
//  - Sequences multi-cycle waits (data-memory handshake, mul/div) via a 3-state FSM with a watchdog.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipeline_hazard_ctrl_if.sv | 34 +++
 rtl/pipeline_hazard_ctrl_fwd.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the RV32 pipeline hazard controller.
// Includes the forwarding-select helper used by hazard_fwd_unit.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } state_e;

  localparam logic [1:0]  FWD_RF    = 2'b00;
  localparam logic [1:0]  FWD_W     = 2'b01;
  localparam logic [1:0]  FWD_M     = 2'b10;
  localparam logic [1:0]  RES_LOAD  = 2'b01;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

  // M-stage result is younger than W, so it wins when both match; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic       we_m,
                                         input logic [4:0] rd_m,
                                         input logic       we_w,
                                         input logic [4:0] rd_w,
                                         input logic [4:0] rs);
    logic [1:0] sel;
    sel = FWD_RF;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = FWD_M;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = FWD_W;
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush/forward controller (slave).
interface pipeline_hazard_ctrl_if;

  logic [4:0] Ra1D, Ra2D, Ra1E, Ra2E;
  logic [4:0] RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       RegWriteM, RegWriteW;
  logic       PCSrcE;
  logic       dmem_req_M, dmem_ack;
  logic       md_start_E, md_done;

  logic       en_PC, en_FD, en_DE, en_EM, en_MW;
  logic       clr_FD, clr_DE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       wait_timeout;

  modport master (
    output Ra1D, Ra2D, Ra1E, Ra2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, dmem_req_M, dmem_ack,
           md_start_E, md_done,
    input  en_PC, en_FD, en_DE, en_EM, en_MW, clr_FD, clr_DE,
           ForwardAE, ForwardBE, wait_timeout
  );

  modport slave (
    input  Ra1D, Ra2D, Ra1E, Ra2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, dmem_req_M, dmem_ack,
           md_start_E, md_done,
    output en_PC, en_FD, en_DE, en_EM, en_MW, clr_FD, clr_DE,
           ForwardAE, ForwardBE, wait_timeout
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// hazard_fwd_unit: purely combinational E-stage forwarding selects and
// load-use stall detection.
module hazard_fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] Ra1D,
  input  logic [4:0] Ra2D,
  input  logic [4:0] Ra1E,
  input  logic [4:0] Ra2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic [1:0] ResultSrcE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       lw_stall
);

  assign ForwardAE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Ra1E);
  assign ForwardBE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Ra2E);

  // A load in E cannot forward to D in time, so the consumer must wait one cycle.
  assign lw_stall = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Ra1D) || (RdE == Ra2D));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/forward controller for the 5-stage RV32 pipeline.
// Optional PIPE_PERF_CNT_EN adds stall_cycles/flush_count performance counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int WCNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_count,
`endif
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [1:0]        S_RUN      = RUN;
  localparam logic [1:0]        S_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0]        S_MD_WAIT  = MD_WAIT;
  localparam logic [WCNT_W-1:0] CNT_LAST   = WCNT_W'(TIMEOUT - 1);

  logic [1:0]        state, state_nxt;
  logic [WCNT_W-1:0] wait_cnt;
  logic              lw_stall;
  logic              in_wait, wait_done, freeze, timeout;
  logic              mem_block, md_block;
  logic              en_pc_c, en_fd_c, en_de_c, en_em_c, en_mw_c;
  logic              clr_fd_c, clr_de_c;

  hazard_fwd_unit u_fwd (
    .Ra1D       (hz.Ra1D),
    .Ra2D       (hz.Ra2D),
    .Ra1E       (hz.Ra1E),
    .Ra2E       (hz.Ra2E),
    .RdE        (hz.RdE),
    .RdM        (hz.RdM),
    .RdW        (hz.RdW),
    .ResultSrcE (hz.ResultSrcE),
    .RegWriteM  (hz.RegWriteM),
    .RegWriteW  (hz.RegWriteW),
    .ForwardAE  (hz.ForwardAE),
    .ForwardBE  (hz.ForwardBE),
    .lw_stall   (lw_stall)
  );

  // A completion seen in the same cycle as the request never enters a wait state.
  always_comb begin
    mem_block = hz.dmem_req_M && !hz.dmem_ack;
    md_block  = hz.md_start_E && !hz.md_done;
    in_wait   = (state != S_RUN);
    wait_done = ((state == S_MEM_WAIT) && hz.dmem_ack) ||
                ((state == S_MD_WAIT)  && hz.md_done);
    freeze    = in_wait ? !wait_done : (mem_block || md_block);
    timeout   = in_wait && !wait_done && (wait_cnt == CNT_LAST);
  end

  always_comb begin
    state_nxt = S_RUN;
    case (state)
      S_RUN: begin
        if (mem_block)
          state_nxt = S_MEM_WAIT;
        else if (md_block)
          state_nxt = S_MD_WAIT;
      end
      S_MEM_WAIT: state_nxt = (hz.dmem_ack || timeout) ? S_RUN : S_MEM_WAIT;
      S_MD_WAIT:  state_nxt = (hz.md_done  || timeout) ? S_RUN : S_MD_WAIT;
      default:    state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!in_wait || (state_nxt == S_RUN))
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // A flush arriving while frozen is simply not acted on yet; PCSrcE stays held upstream.
  always_comb begin
    en_pc_c  = 1'b1;
    en_fd_c  = 1'b1;
    en_de_c  = 1'b1;
    en_em_c  = 1'b1;
    en_mw_c  = 1'b1;
    clr_fd_c = 1'b0;
    clr_de_c = 1'b0;
    if (freeze) begin
      en_pc_c = 1'b0;
      en_fd_c = 1'b0;
      en_de_c = 1'b0;
      en_em_c = 1'b0;
      en_mw_c = 1'b0;
    end else if (hz.PCSrcE) begin
      clr_fd_c = 1'b1;
      clr_de_c = 1'b1;
    end else if (lw_stall) begin
      en_pc_c  = 1'b0;
      en_fd_c  = 1'b0;
      clr_de_c = 1'b1;
    end
  end

  assign hz.en_PC        = en_pc_c;
  assign hz.en_FD        = en_fd_c;
  assign hz.en_DE        = en_de_c;
  assign hz.en_EM        = en_em_c;
  assign hz.en_MW        = en_mw_c;
  assign hz.clr_FD       = clr_fd_c;
  assign hz.clr_DE       = clr_de_c;
  assign hz.wait_timeout = timeout;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!en_pc_c)
        stall_cycles <= stall_cycles + 32'd1;
      if (clr_fd_c)
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (TIMEOUT=8); also builds
// with PIPE_PERF_CNT_EN defined to cover the performance counters.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic n_rst;
  int   total  = 0;
  int   passed = 0;
  int   pulses = 0;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  pipeline_hazard_ctrl_if hz_if ();

  pipeline_hazard_ctrl #(.TIMEOUT(8), .WCNT_W(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
`ifdef PIPE_PERF_CNT_EN
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
`endif
    .hz           (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {en_PC,en_FD,en_DE,en_EM,en_MW,clr_FD,clr_DE}
  logic [6:0] ctl;
  assign ctl = {hz_if.en_PC, hz_if.en_FD, hz_if.en_DE, hz_if.en_EM,
                hz_if.en_MW, hz_if.clr_FD, hz_if.clr_DE};

  localparam logic [6:0] CTL_RUN    = 7'b11111_00;
  localparam logic [6:0] CTL_FREEZE = 7'b00000_00;
  localparam logic [6:0] CTL_FLUSH  = 7'b11111_11;
  localparam logic [6:0] CTL_LWSTL  = 7'b00111_01;

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clearInputs();
    hz_if.Ra1D = '0; hz_if.Ra2D = '0; hz_if.Ra1E = '0; hz_if.Ra2E = '0;
    hz_if.RdE = '0; hz_if.RdM = '0; hz_if.RdW = '0; hz_if.ResultSrcE = '0;
    hz_if.RegWriteM = 1'b0; hz_if.RegWriteW = 1'b0; hz_if.PCSrcE = 1'b0;
    hz_if.dmem_req_M = 1'b0; hz_if.dmem_ack = 1'b0;
    hz_if.md_start_E = 1'b0; hz_if.md_done = 1'b0;
  endtask

  always @(posedge clk) if (hz_if.wait_timeout === 1'b1) pulses++;

  initial begin
    n_rst = 1'b0;
    clearInputs();
    #2;
    checkOutput("reset_ctl", 32'(ctl), 32'(CTL_RUN));
    checkOutput("reset_fwd", 32'({hz_if.ForwardAE, hz_if.ForwardBE}), 32'h0);
    checkOutput("reset_timeout", 32'(hz_if.wait_timeout), 32'h0);
    checkOutput("reset_wait_cnt", 32'(dut.wait_cnt), 32'h0);
`ifdef PIPE_PERF_CNT_EN
    checkOutput("reset_stall_cycles", stall_cycles, 32'h0);
    checkOutput("reset_flush_count", flush_count, 32'h0);
`endif
    applyStimulus();
    n_rst = 1'b1;

    // Forwarding: M beats W, x0 never forwards
    applyStimulus();
    hz_if.RegWriteM = 1'b1; hz_if.RdM = 5'd5; hz_if.RegWriteW = 1'b1; hz_if.RdW = 5'd5;
    hz_if.Ra1E = 5'd5; hz_if.Ra2E = 5'd0;
    #1 checkOutput("fwd_m_over_w", 32'({hz_if.ForwardAE, hz_if.ForwardBE}), 32'b10_00);
    hz_if.RdW = 5'd7; hz_if.Ra2E = 5'd7;
    #1 checkOutput("fwd_a_m_b_w", 32'({hz_if.ForwardAE, hz_if.ForwardBE}), 32'b10_01);
    hz_if.RegWriteM = 1'b0; hz_if.RdW = 5'd5;
    #1 checkOutput("fwd_w_only", 32'({hz_if.ForwardAE, hz_if.ForwardBE}), 32'b01_00);
    hz_if.RegWriteM = 1'b1; hz_if.RdM = 5'd0; hz_if.Ra1E = 5'd0; hz_if.RdW = 5'd0;
    #1 checkOutput("fwd_x0", 32'({hz_if.ForwardAE, hz_if.ForwardBE}), 32'b00_00);

    // Load-use stall and branch priority
    applyStimulus();
    clearInputs();
    hz_if.ResultSrcE = 2'b01; hz_if.RdE = 5'd3; hz_if.Ra2D = 5'd3;
    #1 checkOutput("lw_stall", 32'(ctl), 32'(CTL_LWSTL));
    hz_if.PCSrcE = 1'b1;
    #1 checkOutput("flush_over_lw", 32'(ctl), 32'(CTL_FLUSH));
    hz_if.PCSrcE = 1'b0; hz_if.RdE = 5'd0; hz_if.Ra2D = 5'd0;
    #1 checkOutput("lw_rd_x0", 32'(ctl), 32'(CTL_RUN));

    // Data memory wait: ack after 4 cycles
    applyStimulus();
    clearInputs();
    hz_if.dmem_req_M = 1'b1;
    #1 checkOutput("mem_req_cycle", 32'(ctl), 32'(CTL_FREEZE));
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      #1 checkOutput($sformatf("mem_wait_%0d", i), 32'(ctl), 32'(CTL_FREEZE));
    end
    applyStimulus();
    hz_if.dmem_ack = 1'b1;
    #1 checkOutput("mem_ack_cycle", 32'(ctl), 32'(CTL_RUN));
    applyStimulus();
    hz_if.dmem_req_M = 1'b0; hz_if.dmem_ack = 1'b0;
    #1 checkOutput("mem_back_run", 32'(ctl), 32'(CTL_RUN));
    // Ack in the request cycle
    applyStimulus();
    hz_if.dmem_req_M = 1'b1; hz_if.dmem_ack = 1'b1;
    #1 checkOutput("mem_same_cycle_ack", 32'(ctl), 32'(CTL_RUN));
    applyStimulus();
    hz_if.dmem_req_M = 1'b0; hz_if.dmem_ack = 1'b0;
    #1 checkOutput("mem_no_wait_entered", 32'(ctl), 32'(CTL_RUN));

    // Mul/div wait with a branch held during the freeze
    applyStimulus();
    hz_if.md_start_E = 1'b1; hz_if.PCSrcE = 1'b1;
    #1 checkOutput("md_start_cycle", 32'(ctl), 32'(CTL_FREEZE));
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      #1 checkOutput($sformatf("md_wait_%0d", i), 32'(ctl), 32'(CTL_FREEZE));
    end
    applyStimulus();
    hz_if.md_done = 1'b1;
    #1 checkOutput("md_done_flush", 32'(ctl), 32'(CTL_FLUSH));
    applyStimulus();
    clearInputs();
    #1 checkOutput("md_back_run", 32'(ctl), 32'(CTL_RUN));

    // Watchdog: ack never arrives, TIMEOUT=8
    pulses = 0;
    applyStimulus();
    hz_if.dmem_req_M = 1'b1;
    #1 checkOutput("wd_req_cycle_to", 32'(hz_if.wait_timeout), 32'h0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus();
      #1 checkOutput($sformatf("wd_to_cycle_%0d", k), 32'(hz_if.wait_timeout), (k == 7) ? 32'h1 : 32'h0);
      checkOutput($sformatf("wd_ctl_cycle_%0d", k), 32'(ctl), 32'(CTL_FREEZE));
    end
    applyStimulus();
    hz_if.dmem_req_M = 1'b0;
    #1 checkOutput("wd_after_ctl", 32'(ctl), 32'(CTL_RUN));
    checkOutput("wd_after_to", 32'(hz_if.wait_timeout), 32'h0);
    checkOutput("wd_pulse_count", 32'(pulses), 32'h1);

    // Async reset in the middle of a memory wait
    applyStimulus();
    hz_if.dmem_req_M = 1'b1;
    applyStimulus();
    applyStimulus();
    #1 checkOutput("rst_pre_frozen", 32'(ctl), 32'(CTL_FREEZE));
    n_rst = 1'b0;
    hz_if.dmem_req_M = 1'b0;
    #1 checkOutput("rst_mid_ctl", 32'(ctl), 32'(CTL_RUN));
    checkOutput("rst_mid_wait_cnt", 32'(dut.wait_cnt), 32'h0);
`ifdef PIPE_PERF_CNT_EN
    checkOutput("rst_mid_stall_cycles", stall_cycles, 32'h0);
    checkOutput("rst_mid_flush_count", flush_count, 32'h0);
`endif
    applyStimulus();
    n_rst = 1'b1;
    hz_if.dmem_ack = 1'b1;
    #1 checkOutput("rst_late_ack", 32'(ctl), 32'(CTL_RUN));
    applyStimulus();
    hz_if.dmem_ack = 1'b0;
    #1 checkOutput("rst_after_ack", 32'(ctl), 32'(CTL_RUN));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
